// File: rtl/act_pkg.sv
// Shared definitions for the streaming activation unit: activation mode
// encodings and the lane packing helper used by the top and the bench.
package act_pkg;

  localparam logic [1:0] ACT_BYPASS = 2'd0;
  localparam logic [1:0] ACT_RELU   = 2'd1;
  localparam logic [1:0] ACT_LEAKY  = 2'd2;
  localparam logic [1:0] ACT_CLIP   = 2'd3;

  // Bit offset of a lane inside a packed beat (lane k at [k*width +: width]).
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/relu_lane_act.sv
// Combinational activation of one signed lane, with a flag marking lanes the
// activation forced to zero (feeds the per-frame sparsity statistic).
module relu_lane_act
  import act_pkg::*;
#(
  parameter int BITWIDTH   = 8,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [BITWIDTH-1:0] x_i,
  input  logic        [1:0]          mode_i,
  input  logic signed [BITWIDTH-1:0] thr_i,
  input  logic signed [BITWIDTH-1:0] clip_i,
  output logic signed [BITWIDTH-1:0] y_o,
  output logic                       zeroed_o
);

  localparam logic signed [BITWIDTH-1:0] ZERO = {BITWIDTH{1'b0}};

  // Per-mode transfer function; a non-positive ceiling in clip mode zeroes the lane.
  always_comb begin
    y_o = x_i;
    case (mode_i)
      ACT_BYPASS: y_o = x_i;
      ACT_RELU: begin
        if (x_i <= thr_i) y_o = ZERO;
        else              y_o = x_i;
      end
      ACT_LEAKY: begin
        if (x_i < ZERO) y_o = x_i >>> LEAK_SHIFT;
        else            y_o = x_i;
      end
      ACT_CLIP: begin
        if ((x_i <= ZERO) || (clip_i <= ZERO)) y_o = ZERO;
        else if (x_i > clip_i)                 y_o = clip_i;
        else                                   y_o = x_i;
      end
      default: y_o = x_i;
    endcase
  end

  // A zero input only counts as zeroed in the modes that actively clamp at zero.
  assign zeroed_o = (y_o == ZERO) &&
                    ((x_i != ZERO) || (mode_i == ACT_RELU) || (mode_i == ACT_CLIP));

endmodule

// File: rtl/relu_stream_act.sv
// Two-stage valid/ready activation pipeline: S1 holds the beat and its frame
// config, S2 holds the activated result; also tracks frame position and zero count.
module relu_stream_act
  import act_pkg::*;
#(
  parameter int BITWIDTH    = 8,
  parameter int LANES       = 4,
  parameter int FRAME_BEATS = 588,
  parameter int LEAK_SHIFT  = 3,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic        [1:0]           cfg_mode,
  input  logic signed [BITWIDTH-1:0]  cfg_thresh,
  input  logic signed [BITWIDTH-1:0]  cfg_clip,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*BITWIDTH-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*BITWIDTH-1:0]   out_data,
  output logic                        out_last,
  output logic [CNT_W-1:0]            zero_cnt,
  output logic                        zero_cnt_vld
);

  localparam int DW = LANES * BITWIDTH;
  localparam int BCW = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;
  localparam int ZW = $clog2(LANES + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(FRAME_BEATS - 1);
  localparam logic [BCW-1:0] BEAT_ZERO = {BCW{1'b0}};
  localparam logic signed [BITWIDTH-1:0] CLIP_MAX = {1'b0, {(BITWIDTH-1){1'b1}}};

  logic                       s1_v_q, s1_last_q;
  logic [DW-1:0]              s1_data_q;
  logic [1:0]                 s1_mode_q, cfg_mode_q, beat_mode_s;
  logic signed [BITWIDTH-1:0] s1_thr_q, s1_clip_q, cfg_thr_q, cfg_clip_q;
  logic signed [BITWIDTH-1:0] beat_thr_s, beat_clip_s;
  logic [BCW-1:0]             beat_cnt_q, beat_cnt_d;
  logic                       s2_v_q, out_last_q;
  logic [DW-1:0]              out_data_q, y_s;
  logic [ZW-1:0]              s2_zeros_q, beat_zeros_s;
  logic [LANES-1:0]           zeroed_s;
  logic [CNT_W-1:0]           run_cnt_q, run_cnt_d, run_sat_s, zero_cnt_q, zero_cnt_d;
  logic [CNT_W:0]             run_sum_s;
  logic                       zero_vld_q;
  logic                       s2_adv_s, s1_adv_s, in_fire_s, out_fire_s, frame_start_s;

  assign s2_adv_s      = !s2_v_q || out_ready;
  assign s1_adv_s      = !s1_v_q || s2_adv_s;
  assign in_fire_s     = in_valid && s1_adv_s;
  assign out_fire_s    = s2_v_q && out_ready;
  assign frame_start_s = (beat_cnt_q == BEAT_ZERO);

  assign in_ready     = s1_adv_s;
  assign out_valid    = s2_v_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign zero_cnt     = zero_cnt_q;
  assign zero_cnt_vld = zero_vld_q;

  // The first beat of a frame uses the live cfg; later beats reuse the latched copy.
  always_comb begin
    if (frame_start_s) begin
      beat_mode_s = cfg_mode;
      beat_thr_s  = cfg_thresh;
      beat_clip_s = cfg_clip;
    end else begin
      beat_mode_s = cfg_mode_q;
      beat_thr_s  = cfg_thr_q;
      beat_clip_s = cfg_clip_q;
    end
  end

  // Frame position and sparsity accumulator next-state.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (in_fire_s) begin
      if (beat_cnt_q == LAST_BEAT) beat_cnt_d = BEAT_ZERO;
      else                         beat_cnt_d = beat_cnt_q + BCW'(1);
    end else begin
      beat_cnt_d = beat_cnt_q;
    end
    run_sum_s = {1'b0, run_cnt_q} + (CNT_W+1)'(s2_zeros_q);
    if (run_sum_s[CNT_W]) run_sat_s = {CNT_W{1'b1}};
    else                  run_sat_s = run_sum_s[CNT_W-1:0];
    run_cnt_d  = run_cnt_q;
    zero_cnt_d = zero_cnt_q;
    if (out_fire_s) begin
      if (out_last_q) begin
        run_cnt_d  = {CNT_W{1'b0}};
        zero_cnt_d = run_sat_s;
      end else begin
        run_cnt_d  = run_sat_s;
      end
    end else begin
      run_cnt_d = run_cnt_q;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    relu_lane_act #(
      .BITWIDTH   (BITWIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x_i      (s1_data_q[lane_lsb(k, BITWIDTH) +: BITWIDTH]),
      .mode_i   (s1_mode_q),
      .thr_i    (s1_thr_q),
      .clip_i   (s1_clip_q),
      .y_o      (y_s[lane_lsb(k, BITWIDTH) +: BITWIDTH]),
      .zeroed_o (zeroed_s[k])
    );
  end

  // Number of zeroed lanes in the beat currently in S1.
  always_comb begin
    beat_zeros_s = {ZW{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      beat_zeros_s = beat_zeros_s + ZW'(zeroed_s[k]);
    end
  end

  // S1 stage, frame cfg latch and beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q     <= 1'b0;
      s1_data_q  <= {DW{1'b0}};
      s1_last_q  <= 1'b0;
      s1_mode_q  <= ACT_RELU;
      s1_thr_q   <= {BITWIDTH{1'b0}};
      s1_clip_q  <= CLIP_MAX;
      cfg_mode_q <= ACT_RELU;
      cfg_thr_q  <= {BITWIDTH{1'b0}};
      cfg_clip_q <= CLIP_MAX;
      beat_cnt_q <= BEAT_ZERO;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      if (s1_adv_s) begin
        s1_v_q <= in_valid;
        if (in_valid) begin
          s1_data_q <= in_data;
          s1_last_q <= (beat_cnt_q == LAST_BEAT);
          s1_mode_q <= beat_mode_s;
          s1_thr_q  <= beat_thr_s;
          s1_clip_q <= beat_clip_s;
        end
      end
      if (in_fire_s && frame_start_s) begin
        cfg_mode_q <= cfg_mode;
        cfg_thr_q  <= cfg_thresh;
        cfg_clip_q <= cfg_clip;
      end
    end
  end

  // S2 stage and zero-count statistic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q     <= 1'b0;
      out_data_q <= {DW{1'b0}};
      out_last_q <= 1'b0;
      s2_zeros_q <= {ZW{1'b0}};
      run_cnt_q  <= {CNT_W{1'b0}};
      zero_cnt_q <= {CNT_W{1'b0}};
      zero_vld_q <= 1'b0;
    end else begin
      if (s2_adv_s) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          out_data_q <= y_s;
          out_last_q <= s1_last_q;
          s2_zeros_q <= beat_zeros_s;
        end
      end
      run_cnt_q  <= run_cnt_d;
      zero_cnt_q <= zero_cnt_d;
      zero_vld_q <= out_fire_s && out_last_q;
    end
  end

endmodule

// File: tb/tb_relu_stream_act.sv
// Randomised self-checking bench for relu_stream_act against a queue-based
// reference model of the activation rules, frame framing and zero statistic.
module tb_relu_stream_act;

  localparam int BW = 8;
  localparam int LN = 4;
  localparam int FB = 4;
  localparam int LS = 3;
  localparam int CW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        cfg_mode;
  logic signed [7:0] cfg_thresh, cfg_clip;
  logic              in_valid, in_ready, out_valid, out_ready, out_last, zero_cnt_vld;
  logic [31:0]       in_data, out_data;
  logic [15:0]       zero_cnt;

  always #5 clk = ~clk;

  relu_stream_act #(
    .BITWIDTH(BW), .LANES(LN), .FRAME_BEATS(FB), .LEAK_SHIFT(LS), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_thresh(cfg_thresh),
    .cfg_clip(cfg_clip), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .zero_cnt(zero_cnt), .zero_cnt_vld(zero_cnt_vld)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [32:0] exp_q[$], obs_q[$];
  int exp_zc[$], obs_zc[$];
  int m_pos, m_mode, m_thr, m_clip, m_run, rdy_mode;

  // Output monitor: record every transferred beat and every statistic pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) obs_q.push_back({out_last, out_data});
      if (zero_cnt_vld) obs_zc.push_back(int'(zero_cnt));
    end
  end

  function automatic logic [31:0] lanes(input int l0, input int l1, input int l2, input int l3);
    return {l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  function automatic int ref_act(input int x, input int mode, input int thr, input int clip);
    int q;
    case (mode)
      0: return x;
      1: return (x <= thr) ? 0 : x;
      2: begin
        if (x >= 0) return x;
        q = x / (2 ** LS);
        if (q * (2 ** LS) != x) q = q - 1;
        return q;
      end
      default: begin
        if (x <= 0 || clip <= 0) return 0;
        return (x > clip) ? clip : x;
      end
    endcase
  endfunction

  task automatic model_accept(input logic [31:0] d);
    logic [31:0] y;
    logic [7:0] b;
    int x, yv, zeros;
    logic last;
    if (m_pos == 0) begin
      m_mode = int'(cfg_mode);
      m_thr  = int'(cfg_thresh);
      m_clip = int'(cfg_clip);
    end
    zeros = 0;
    for (int k = 0; k < LN; k++) begin
      b = d[k*BW +: BW];
      x = int'($signed(b));
      yv = ref_act(x, m_mode, m_thr, m_clip);
      y[k*BW +: BW] = yv[7:0];
      if (yv == 0 && (x != 0 || m_mode == 1 || m_mode == 3)) zeros++;
    end
    last = (m_pos == FB - 1);
    exp_q.push_back({last, y});
    m_run = (m_run + zeros > 65535) ? 65535 : m_run + zeros;
    if (last) begin
      exp_zc.push_back(m_run);
      m_run = 0;
    end
    m_pos = (m_pos + 1) % FB;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ~out_ready;
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic send_beat(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(d);
        step();
        in_valid = 1'b0;
        return;
      end
      step();
    end
    n_tests++; n_fail++;
    $display("FAIL send_timeout: in_ready never high, required 1 within 100 cycles");
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    rdy_mode = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 300 && obs_q.size() < exp_q.size(); c++) step();
    repeat (3) step();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0; rdy_mode = 0;
    cfg_mode = 2'd1; cfg_thresh = 8'sd0; cfg_clip = 8'sd127;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete(); exp_zc.delete(); obs_zc.delete();
    m_pos = 0; m_run = 0;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL rst_out_data: got %h want 0", out_data); end
    n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    n_tests++; if (zero_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_zero_cnt: got %h want 0", zero_cnt); end
    n_tests++; if (zero_cnt_vld !== 1'b0) begin n_fail++; $display("FAIL rst_zero_vld: got %b want 0", zero_cnt_vld); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_relu();
    apply_reset();
    cfg_mode = 2'd1; cfg_thresh = 8'sd0;
    send_beat(lanes(-5, 0, 3, 127));
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL relu_early_valid: got %b want 0", out_valid); end
    step();
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL relu_latency: got %b want 1", out_valid); end
    n_tests++; if (out_data !== 32'h7F030000) begin n_fail++; $display("FAIL relu_data: got %h want 7f030000", out_data); end
    step();
    repeat (3) send_beat(lanes(-5, 0, 3, 127));
    drain();
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL relu_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL relu_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_tests++; if (obs_zc.size() != 1 || obs_zc[0] != 8) begin n_fail++; $display("FAIL relu_zero_cnt: got %0d pulses first %0d want 1 pulse of 8", obs_zc.size(), (obs_zc.size() > 0) ? obs_zc[0] : -1); end
  endtask

  task automatic test_leaky_clip();
    apply_reset();
    cfg_mode = 2'd2;
    repeat (4) send_beat(lanes(-16, -1, -128, 9));
    cfg_mode = 2'd3; cfg_clip = 8'sd6;
    repeat (4) send_beat(lanes(-3, 4, 6, 100));
    cfg_clip = -8'sd3;
    repeat (4) send_beat($urandom());
    drain();
    n_tests++; if (obs_q.size() > 0 && obs_q[0] !== {1'b0, 32'h09F0FFFE}) begin n_fail++; $display("FAIL leaky_data: got %h want 009f0fffe", obs_q[0]); end
    n_tests++; if (obs_q.size() > 4 && obs_q[4] !== {1'b0, 32'h06060400}) begin n_fail++; $display("FAIL clip_data: got %h want 006060400", obs_q[4]); end
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL lc_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL lc_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_tests++; if (obs_zc.size() != exp_zc.size()) begin n_fail++; $display("FAIL lc_zc_count: got %0d want %0d", obs_zc.size(), exp_zc.size()); end
    for (int i = 0; i < exp_zc.size() && i < obs_zc.size(); i++) begin
      n_tests++; if (obs_zc[i] != exp_zc[i]) begin n_fail++; $display("FAIL lc_zc%0d: got %0d want %0d", i, obs_zc[i], exp_zc[i]); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] snap_d;
    logic snap_l;
    apply_reset();
    cfg_mode = 2'd0;
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) send_beat($urandom());
    rdy_mode = 3;
    step();
    @(negedge clk);
    snap_d = out_data; snap_l = out_last;
    for (int c = 0; c < 5; c++) begin
      n_tests++; if (out_valid !== 1'b1 || out_data !== snap_d || out_last !== snap_l) begin
        n_fail++; $display("FAIL stall_hold%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", c, out_valid, out_data, out_last, snap_d, snap_l);
      end
      step();
      @(negedge clk);
    end
    drain();
    n_tests++; if (obs_q.size() != 10 || exp_q.size() != 10) begin n_fail++; $display("FAIL stall_count: got %0d want 10", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL stall_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_frames();
    apply_reset();
    cfg_mode = 2'd1; cfg_thresh = 8'sd0;
    repeat (8) send_beat(32'hFFFFFFFF);
    drain();
    n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL frm_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_tests++; if (obs_q[i] !== {(i == 3 || i == 7), 32'h0}) begin n_fail++; $display("FAIL frm_beat%0d: got %h want last=%0d data 0", i, obs_q[i], (i == 3 || i == 7)); end
    end
    n_tests++; if (obs_zc.size() != 2) begin n_fail++; $display("FAIL frm_zc_pulses: got %0d want 2", obs_zc.size()); end
    for (int i = 0; i < obs_zc.size(); i++) begin
      n_tests++; if (obs_zc[i] != 16) begin n_fail++; $display("FAIL frm_zc%0d: got %0d want 16", i, obs_zc[i]); end
    end
  endtask

  task automatic test_cfg_midframe();
    apply_reset();
    cfg_mode = 2'd1; cfg_thresh = 8'sd0;
    repeat (2) send_beat(32'hF9F9F9F9);
    cfg_mode = 2'd0;
    repeat (6) send_beat(32'hF9F9F9F9);
    drain();
    n_tests++; if (obs_q.size() != 8) begin n_fail++; $display("FAIL cfg_count: got %0d want 8", obs_q.size()); end
    for (int i = 0; i < 8 && i < obs_q.size(); i++) begin
      n_tests++; if (obs_q[i][31:0] !== ((i < 4) ? 32'h0 : 32'hF9F9F9F9)) begin n_fail++; $display("FAIL cfg_beat%0d: got %h want %h", i, obs_q[i][31:0], (i < 4) ? 32'h0 : 32'hF9F9F9F9); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      for (int b = 0; b < FB; b++) begin
        if (b == 0 || $urandom_range(0, 2) == 0) begin
          cfg_mode = 2'($urandom_range(0, 3));
          cfg_thresh = 8'($urandom_range(0, 255));
          cfg_clip = 8'($urandom_range(0, 255));
        end
        if ($urandom_range(0, 3) == 0) step();
        send_beat($urandom());
      end
    end
    drain();
    n_tests++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rnd_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_tests++; if (obs_zc.size() != exp_zc.size()) begin n_fail++; $display("FAIL rnd_zc_count: got %0d want %0d", obs_zc.size(), exp_zc.size()); end
    for (int i = 0; i < exp_zc.size() && i < obs_zc.size(); i++) begin
      n_tests++; if (obs_zc[i] != exp_zc[i]) begin n_fail++; $display("FAIL rnd_zc%0d: got %0d want %0d", i, obs_zc[i], exp_zc[i]); end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    rdy_mode = 3;
    out_ready = 1'b0;
    cfg_mode = 2'd1;
    send_beat($urandom());
    send_beat($urandom());
    n_tests++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_full: got in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_out_valid: got %b want 0", out_valid); end
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ar_in_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete(); obs_q.delete(); exp_zc.delete(); obs_zc.delete();
    m_pos = 0; m_run = 0;
    rdy_mode = 0;
    cfg_mode = 2'd0;
    step();
    repeat (4) send_beat($urandom());
    drain();
    n_tests++; if (obs_q.size() != 4) begin n_fail++; $display("FAIL ar_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_tests++; if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ar_beat%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_tests++; if (obs_q.size() > 3 && obs_q[3][32] !== 1'b1) begin n_fail++; $display("FAIL ar_last: got %b want 1", obs_q[3][32]); end
  endtask

  initial begin
    test_reset();
    test_relu();
    test_leaky_clip();
    test_stall();
    test_frames();
    test_cfg_midframe();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded 2 ms, required completion");
    $fatal(1);
  end

endmodule
